// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM soft-start/soft-stop controller.
package pwm_pkg;

  localparam int PWM_SIZE_DFLT = 32;
  localparam int RATE_W_DFLT   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } ramp_state_t;

  typedef struct packed {
    logic [PWM_SIZE_DFLT-1:0] period;
    logic [PWM_SIZE_DFLT-1:0] target;
    logic [PWM_SIZE_DFLT-1:0] step;
    logic [RATE_W_DFLT-1:0]   rate;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Period down-counter: held at period-1 while stopped, one-cycle tick at
// terminal count, reload from the period presented on that cycle.
module pwm_period_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_run,
  input  logic [W-1:0] i_period,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || !i_run || (r_cnt == '0)) begin
      r_cnt <= i_period - W'(1);
    end else begin
      r_cnt <= r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Sequencer for one PWM driver channel: config handshake, soft-start to a
// target duty at period boundaries, hold, and soft-stop before driver reset.
//
// state | meaning
// IDLE  | driver in reset, duty 0, waiting for en with a stored config
// RAMP  | stepping duty toward the stored target
// HOLD  | duty at target, new config accepted
// STOP  | stepping duty toward 0, then back to IDLE
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int PWM_SIZE = PWM_SIZE_DFLT,
  parameter int RATE_W   = RATE_W_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PWM_SIZE-1:0] cfg_period,
  input  logic [PWM_SIZE-1:0] cfg_target,
  input  logic [PWM_SIZE-1:0] cfg_step,
  input  logic [RATE_W-1:0]   cfg_rate,
  output logic                pwm_rst,
  output logic [PWM_SIZE-1:0] pwm_period,
  output logic [PWM_SIZE-1:0] pwm_duty,
  output logic                period_tick,
  output logic                at_target,
  output logic                busy
);

  ramp_state_t         r_state;
  logic                r_has_cfg;
  logic [PWM_SIZE-1:0] r_period, r_target, r_step, r_duty, r_pwm_period;
  logic [RATE_W-1:0]   r_rate_m1, r_div;
  logic                r_pwm_rst;

  logic                w_tick, w_accept, w_step_evt;
  logic [PWM_SIZE-1:0] w_cap_period, w_cap_target, w_eff_target;
  logic [PWM_SIZE-1:0] w_ramp_duty, w_base_duty, w_next_duty;
  logic [RATE_W-1:0]   w_cap_rate_m1;
  logic [PWM_SIZE:0]   w_up, w_dn;

  pwm_period_timer #(.W(PWM_SIZE)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_run    (!r_pwm_rst),
    .i_period (r_period),
    .o_tick   (w_tick)
  );

  assign cfg_ready   = (r_state == IDLE) || (r_state == HOLD);
  assign busy        = (r_state != IDLE);
  assign at_target   = (r_state == HOLD);
  assign period_tick = w_tick;
  assign pwm_rst     = r_pwm_rst;
  assign pwm_period  = r_pwm_period;
  assign pwm_duty    = r_duty;

  assign w_accept      = cfg_valid && cfg_ready;
  assign w_cap_period  = (cfg_period == '0) ? PWM_SIZE'(1) : cfg_period;
  assign w_cap_target  = (cfg_target > w_cap_period) ? w_cap_period : cfg_target;
  assign w_cap_rate_m1 = (cfg_rate == '0) ? '0 : cfg_rate - RATE_W'(1);
  assign w_step_evt    = w_tick && (r_div == '0);
  assign w_eff_target  = (r_state == STOP) ? '0 : r_target;

  // One extra bit so overshoot past the target (or below zero) is visible.
  assign w_up = {1'b0, r_duty} + {1'b0, r_step};
  assign w_dn = {1'b0, r_duty} - {1'b0, r_step};

  always_comb begin
    w_ramp_duty = r_duty;
    if (r_step == '0) begin
      w_ramp_duty = w_eff_target;
    end else if (r_duty < w_eff_target) begin
      w_ramp_duty = (w_up >= {1'b0, w_eff_target}) ? w_eff_target : w_up[PWM_SIZE-1:0];
    end else if (r_duty > w_eff_target) begin
      w_ramp_duty = (w_dn[PWM_SIZE] || (w_dn[PWM_SIZE-1:0] <= w_eff_target))
                    ? w_eff_target : w_dn[PWM_SIZE-1:0];
    end
  end

  // A shorter period only lands at a reload, so duty is clamped there too.
  assign w_base_duty = (w_step_evt && ((r_state == RAMP) || (r_state == STOP)))
                       ? w_ramp_duty : r_duty;
  assign w_next_duty = (w_tick && (w_base_duty > r_period)) ? r_period : w_base_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_accept) begin
      r_div <= w_cap_rate_m1;
    end else if (r_state == IDLE) begin
      r_div <= r_rate_m1;
    end else if (w_tick) begin
      r_div <= (r_div == '0) ? r_rate_m1 : r_div - RATE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_has_cfg    <= 1'b0;
      r_period     <= '0;
      r_target     <= '0;
      r_step       <= '0;
      r_rate_m1    <= '0;
      r_duty       <= '0;
      r_pwm_rst    <= 1'b1;
      r_pwm_period <= '0;
    end else begin
      if (w_accept) begin
        r_has_cfg <= 1'b1;
        r_period  <= w_cap_period;
        r_target  <= w_cap_target;
        r_step    <= cfg_step;
        r_rate_m1 <= w_cap_rate_m1;
      end
      if (r_pwm_rst || w_tick) begin
        r_pwm_period <= r_period;
      end
      r_duty <= w_next_duty;
      case (r_state)
        IDLE: begin
          if (en && r_has_cfg) r_state <= RAMP;
        end
        RAMP: begin
          r_pwm_rst <= 1'b0;
          if (!en) begin
            r_state <= STOP;
          end else if ((r_duty == r_target) || (w_step_evt && (w_ramp_duty == r_target))) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (!en) begin
            r_state <= STOP;
          end else if (w_accept) begin
            r_state <= RAMP;
          end
        end
        STOP: begin
          if (en) begin
            r_state <= RAMP;
          end else if (w_step_evt && (w_ramp_duty == '0)) begin
            r_state   <= IDLE;
            r_pwm_rst <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus randomized
// ramp-up/ramp-down runs against a tick-level arithmetic model.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_period = '0, cfg_target = '0, cfg_step = '0;
  logic [15:0] cfg_rate = '0;
  logic        pwm_rst;
  logic [31:0] pwm_period, pwm_duty;
  logic        period_tick, at_target, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_target(cfg_target),
    .cfg_step(cfg_step), .cfg_rate(cfg_rate),
    .pwm_rst(pwm_rst), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
    .period_tick(period_tick), .at_target(at_target), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Duty after one step event: move by stp toward tgt, never past it.
  function automatic int move(input int d, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (d < tgt) return (d + stp > tgt) ? tgt : d + stp;
    return (d - stp < tgt) ? tgt : d - stp;
  endfunction

  task automatic wait_tick(input string nm, input int exp_iv);
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_tick && n < 400);
    checks++;
    if (!period_tick) begin
      errors++;
      $display("FAIL %s tick: none within %0d cycles", nm, n);
    end else if (cyc - last_tick != exp_iv) begin
      errors++;
      $display("FAIL %s tick interval: got %0d expected %0d", nm, cyc - last_tick, exp_iv);
    end
    last_tick = cyc;
  endtask

  task automatic reset_dut();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_cfg(input int p, input int t, input int s, input int r);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready before offer: got %b expected 1", cfg_ready);
    end
    cfg_period = 32'(p); cfg_target = 32'(t); cfg_step = 32'(s); cfg_rate = 16'(r);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic start_run();
    int n = 0;
    en = 1'b1;
    do begin
      step();
      n++;
    end while (pwm_rst && n < 6);
    checks++;
    if (pwm_rst !== 1'b0 || n > 2) begin
      errors++;
      $display("FAIL pwm_rst release: pwm_rst=%b after %0d cycles, expected 0 within 2", pwm_rst, n);
    end
    last_tick = cyc - 1;
  endtask

  // Ramp to target (and optionally back to 0), checking every tick.
  task automatic ramp_run(input string nm, input int p, input int t, input int s,
                          input int r, input bit do_stop);
    int pe = (p == 0) ? 1 : p;
    int te = (t > pe) ? pe : t;
    int re = (r == 0) ? 1 : r;
    int d = 0;
    int n = 0;
    bit up = 1'b1;
    bit done = 1'b0;
    load_cfg(p, t, s, r);
    start_run();
    for (int k = 0; k < 200 && !done; k++) begin
      wait_tick(nm, pe);
      n++;
      if (n % re == 0) d = move(d, up ? te : 0, s);
      step();
      checks++;
      if (pwm_duty !== 32'(d)) begin
        errors++;
        $display("FAIL %s duty after tick %0d: got %0d expected %0d", nm, n, pwm_duty, d);
      end
      checks++;
      if (up) begin
        if (at_target !== (d == te) || cfg_ready !== (d == te)) begin
          errors++;
          $display("FAIL %s at_target/cfg_ready tick %0d: got %b/%b expected %b",
                   nm, n, at_target, cfg_ready, d == te);
        end
        if (d == te) begin
          if (do_stop) begin
            en = 1'b0;
            up = 1'b0;
          end else begin
            done = 1'b1;
          end
        end
      end else begin
        if (busy !== (d != 0) || pwm_rst !== (d == 0)) begin
          errors++;
          $display("FAIL %s busy/pwm_rst tick %0d: got %b/%b expected %b/%b",
                   nm, n, busy, pwm_rst, d != 0, d == 0);
        end
        if (d == 0) done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s completion: got unfinished expected finished", nm);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (pwm_rst !== 1'b1 || pwm_period !== 32'd0 || pwm_duty !== 32'd0 || period_tick !== 1'b0
        || at_target !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset values: got rst=%b per=%0d duty=%0d tick=%b at=%b busy=%b rdy=%b expected 1 0 0 0 0 0 1",
               pwm_rst, pwm_period, pwm_duty, period_tick, at_target, busy, cfg_ready);
    end
  endtask

  task automatic test_ramp_basic();
    reset_dut(); ramp_run("basic", 10, 6, 2, 1, 1'b0);
    reset_dut(); ramp_run("rate3", 10, 6, 2, 3, 1'b0);
    reset_dut(); ramp_run("sat", 10, 7, 3, 1, 1'b0);
    reset_dut(); ramp_run("clamp", 10, 15, 4, 1, 1'b0);
    checks++;
    if (pwm_duty !== 32'd10 || pwm_period !== 32'd10) begin
      errors++;
      $display("FAIL clamp final: got duty=%0d period=%0d expected 10 10", pwm_duty, pwm_period);
    end
  endtask

  task automatic test_stop_reenter();
    int exp_d[4] = '{4, 2, 4, 6};
    reset_dut();
    ramp_run("stop", 10, 6, 2, 1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) en = 1'b1;
      wait_tick("stop", 10);
      step();
      checks++;
      if (pwm_duty !== 32'(exp_d[i]) || at_target !== (i == 3) || pwm_rst !== 1'b0) begin
        errors++;
        $display("FAIL stop/reenter step %0d: got duty=%0d at=%b rst=%b expected %0d %b 0",
                 i, pwm_duty, at_target, pwm_rst, exp_d[i], i == 3);
      end
    end
  endtask

  task automatic test_period_change();
    reset_dut();
    ramp_run("perchg", 10, 6, 2, 1, 1'b0);
    step(); step();
    checks++;
    if (pwm_period !== 32'd10) begin
      errors++;
      $display("FAIL perchg old period: got %0d expected 10", pwm_period);
    end
    load_cfg(20, 6, 2, 1);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL perchg cfg_ready in RAMP: got %b expected 0", cfg_ready);
    end
    wait_tick("perchg old", 10);
    wait_tick("perchg new", 20);
    checks++;
    if (pwm_period !== 32'd20 || at_target !== 1'b1 || pwm_duty !== 32'd6) begin
      errors++;
      $display("FAIL perchg after reload: got per=%0d at=%b duty=%0d expected 20 1 6",
               pwm_period, at_target, pwm_duty);
    end
    load_cfg(8, 6, 2, 1);
    wait_tick("tick+cfg old", 20);
    wait_tick("tick+cfg new", 8);
  endtask

  task automatic test_back_to_back();
    int exp_d[4] = '{3, 0, 3, 4};
    step();
    cfg_period = 32'd8; cfg_target = 32'd4; cfg_step = 32'd3; cfg_rate = 16'd1;
    cfg_valid = 1'b1;
    en = 1'b0;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (at_target !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg+en_fall state: got at=%b busy=%b rdy=%b expected 0 1 0",
               at_target, busy, cfg_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) start_run();
      wait_tick("b2b", 8);
      step();
      checks++;
      if (pwm_duty !== 32'(exp_d[i]) || busy !== (i != 1) || at_target !== (i == 3)) begin
        errors++;
        $display("FAIL b2b step %0d: got duty=%0d busy=%b at=%b expected %0d %b %b",
                 i, pwm_duty, busy, at_target, exp_d[i], i != 1, i == 3);
      end
    end
  endtask

  task automatic test_rst_mid();
    int bad = 0;
    reset_dut();
    load_cfg(10, 6, 2, 1);
    start_run();
    wait_tick("rstmid", 10); step();
    wait_tick("rstmid", 10); step();
    checks++;
    if (pwm_duty !== 32'd4) begin
      errors++;
      $display("FAIL rstmid pre-reset duty: got %0d expected 4", pwm_duty);
    end
    rst = 1'b1;
    step();
    checks++;
    if (pwm_rst !== 1'b1 || pwm_period !== 32'd0 || pwm_duty !== 32'd0 || period_tick !== 1'b0
        || at_target !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid values: got rst=%b per=%0d duty=%0d tick=%b at=%b busy=%b rdy=%b expected 1 0 0 0 0 0 1",
               pwm_rst, pwm_period, pwm_duty, period_tick, at_target, busy, cfg_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy !== 1'b0 || pwm_rst !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid no-config idle: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int p = $urandom_range(12, 2);
      int t = $urandom_range(15, 1);
      int s = $urandom_range(5, 0);
      int r = $urandom_range(3, 0);
      reset_dut();
      ramp_run($sformatf("rand%0d p%0d t%0d s%0d r%0d", it, p, t, s, r), p, t, s, r, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_basic();
    test_stop_reenter();
    test_period_change();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Sequencing controller for one PWM driver channel. It owns the driver's period, duty and reset inputs. It accepts a configuration through a valid/ready handshake, soft-starts the duty from 0 to a target in fixed steps at period boundaries, and holds the duty at the target. When disabled, it soft-stops (ramps the duty to 0) before putting the driver back into reset.

Parameters:
PWM_SIZE, 32, width of period/duty values; must match the driver.
RATE_W, 16, width of the periods-per-step divider.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  level; 1 = run/ramp up, 0 = ramp down then stop
cfg_valid  input  1  config offer
cfg_ready  output  1  config accepted when cfg_valid & cfg_ready
cfg_period  input  PWM_SIZE  period in clk cycles
cfg_target  input  PWM_SIZE  target duty in clk cycles
cfg_step  input  PWM_SIZE  duty increment per ramp step
cfg_rate  input  RATE_W  periods per ramp step
pwm_rst  output  1  reset to driver
pwm_period  output  PWM_SIZE  to driver
pwm_duty  output  PWM_SIZE  to driver
period_tick  output  1  one-cycle pulse at each period boundary
at_target  output  1  duty == target in HOLD
busy  output  1  state != IDLE

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: pwm_rst=1, pwm_period=0, pwm_duty=0, period_tick=0, at_target=0, busy=0, cfg_ready=1. The stored-config flag is cleared.
- Reset mid-operation aborts immediately. There is no ramp-down, and the stored config is discarded.
- Config capture happens on cfg_valid & cfg_ready.
  - cfg_period=0 is stored as 1.
  - cfg_target is clamped to the stored period.
  - cfg_step=0 means jump straight to target.
  - cfg_rate=0 is treated as 1.
- cfg_ready=1 only in IDLE and HOLD.
- States: IDLE, RAMP, HOLD, STOP.
- IDLE:
  - pwm_rst=1 and pwm_duty=0.
  - pwm_period follows the stored period.
  - The period counter is held at period-1.
  - Exit to RAMP when en=1 and a config is stored. pwm_rst drops on the cycle after the transition.
- Period counter:
  - Starts at period-1 on the first cycle with pwm_rst=0 and decrements each cycle.
  - When it reaches 0, period_tick=1 that cycle and the counter reloads period-1. This gives exactly period cycles per tick.
- Step divider: counts ticks; each cfg_rate ticks produces a "step event".
- RAMP:
  - On a step event, duty moves toward target by step. The sum is computed at PWM_SIZE+1 bits and saturated to target in both directions.
  - The new duty is visible on the cycle after the tick, so the driver applies it at the following boundary.
  - When duty==target, go to HOLD.
- HOLD:
  - at_target=1.
  - A new config re-enters RAMP from the current duty toward the new target, with the divider reset.
  - A new period takes effect at the next tick reload, never mid-period. If needed, duty is clamped to the new period at that reload.
- en=0 in RAMP or HOLD: go to STOP.
- STOP:
  - The effective target is 0; ramp down with the stored step and rate.
  - When a step event brings duty to 0, go to IDLE.
  - en=1 during STOP returns to RAMP toward the stored target without a reset glitch.
- Simultaneous events:
  - A config accept and en falling in the same HOLD cycle: the config is stored, and the state is STOP.
  - A tick and a config accept in the same cycle: the tick reload uses the old period.
- at_target clears the cycle the state leaves HOLD.

Decomposition:
- Package pwm_pkg holds:
  - the state enum typedef ramp_state_t (IDLE, RAMP, HOLD, STOP);
  - the default PWM_SIZE localparam;
  - a cfg struct typedef pwm_cfg_t {period, target, step, rate}.
- One natural sub-module is pwm_period_timer: period down-counter, reload, and tick generation.
- Saturating step arithmetic stays in the top module.

Test Plan:
- Reset; load cfg period=10, target=6, step=2, rate=1; raise en:
  - pwm_rst low next cycle;
  - ticks every 10 cycles;
  - pwm_duty 0→2→4→6 after ticks 1, 2, 3;
  - at_target=1 after the third step.
- Same config with rate=3 → duty changes only on every 3rd tick; reaches 6 after tick 9.
- Target=7, step=3, period=10 → duty 3, 6, 7 (saturates); cfg_target=15 → stored target clamped to 10.
- In HOLD at duty 6, drop en:
  - duty 4, 2, 0 on successive ticks;
  - then IDLE with pwm_rst=1 and busy=0.
  - Re-raise en at duty 2 → ramps back up to 6.
- In HOLD, offer period=20 mid-period → old 10-cycle period completes, then 20-cycle ticks follow; cfg_ready=0 during RAMP.
- Assert rst during RAMP at duty 4 → all outputs at reset values next cycle; en=1 without a new config stays in IDLE.
